// File: rtl/gb80_dma_pkg.sv
// Shared constants and state type for the gb80 OAM DMA engine.
package gb80_dma_pkg;

  localparam logic [15:0] MMIO_DMA = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [7:0]  DMA_LEN  = 8'd160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/gb80_dma.sv
// gb80 OAM DMA: copies 160 bytes from {SRC_HI,8'h00} to 0xFE00 after a write to 0xFF46.
// Optional macro DMA_REG_READBACK_EN lets the CPU read SRC_HI back from 0xFF46.
module gb80_dma
  import gb80_dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_we,
  input  logic        mem_re,
  inout  wire  [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  output logic        dma_mem_re,
  output logic        dma_mem_we,
  output logic        cpu_mem_disable
);

  dma_state_t  state_reg;
  logic [7:0]  index_reg;
  logic [7:0]  src_hi_reg;
  logic [7:0]  buffer_reg;
  logic        re_reg;
  logic        we_reg;
  logic        disable_reg;
  logic        addr_oe_reg;
  logic        data_oe_reg;
  logic [15:0] addr_value;

  // Strobes and bus enables are registered alongside the state so that
  // nothing on the CPU side can reach them combinationally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      index_reg   <= 8'h00;
      src_hi_reg  <= 8'h00;
      buffer_reg  <= 8'h00;
      re_reg      <= 1'b0;
      we_reg      <= 1'b0;
      disable_reg <= 1'b0;
      addr_oe_reg <= 1'b0;
      data_oe_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_we && (addr_ext == MMIO_DMA)) begin
            src_hi_reg  <= data_ext;
            state_reg   <= START;
            disable_reg <= 1'b1;
          end
        end
        START: begin
          state_reg   <= READ;
          index_reg   <= 8'h00;
          re_reg      <= 1'b1;
          addr_oe_reg <= 1'b1;
        end
        READ: begin
          buffer_reg  <= data_ext;
          state_reg   <= WRITE;
          re_reg      <= 1'b0;
          we_reg      <= 1'b1;
          data_oe_reg <= 1'b1;
        end
        WRITE: begin
          we_reg      <= 1'b0;
          data_oe_reg <= 1'b0;
          if (index_reg == DMA_LEN - 8'd1) begin
            state_reg   <= IDLE;
            disable_reg <= 1'b0;
            addr_oe_reg <= 1'b0;
          end else begin
            index_reg <= index_reg + 8'd1;
            state_reg <= READ;
            re_reg    <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // index never exceeds 0x9F, so concatenation equals base+i without a carry
  assign addr_value = (state_reg == READ) ? {src_hi_reg, index_reg}
                                          : OAM_BASE + {8'h00, index_reg};

  assign addr_ext        = addr_oe_reg ? addr_value : 16'hzzzz;
  assign dma_mem_re      = re_reg;
  assign dma_mem_we      = we_reg;
  assign cpu_mem_disable = disable_reg;

`ifdef DMA_REG_READBACK_EN
  logic readback;
  assign readback = (state_reg == IDLE) && mem_re && (addr_ext == MMIO_DMA);
  assign data_ext = data_oe_reg ? buffer_reg :
                    readback    ? src_hi_reg : 8'hzz;
`else
  logic unused_cpu_read;
  assign unused_cpu_read = mem_re;
  assign data_ext = data_oe_reg ? buffer_reg : 8'hzz;
`endif

endmodule

// File: tb/tb_gb80_dma.sv
// Randomized bench for gb80_dma: memory model on the shared bus, OAM image checked against a snapshot.
`timescale 1ns/1ps
module tb_gb80_dma;
  import gb80_dma_pkg::*;

  logic        clock;
  logic        reset;
  logic        mem_we;
  logic        mem_re;
  wire  [15:0] addr_ext;
  wire  [7:0]  data_ext;
  logic        dma_mem_re;
  logic        dma_mem_we;
  logic        cpu_mem_disable;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_addr_oe;
  logic        cpu_data_oe;

  logic [7:0]  src_mem [0:65535];
  logic [7:0]  oam     [0:159];
  logic [7:0]  exp_img [0:159];
  logic [7:0]  old_img [0:159];
  int          stray_writes;
  int          checks;
  int          errors;

  // released bus lines read as all-ones
  pullup pu_addr (addr_ext);
  pullup pu_data (data_ext);

  assign addr_ext = cpu_addr_oe ? cpu_addr : 16'hzzzz;
  assign data_ext = cpu_data_oe ? cpu_data : 8'hzz;
  assign data_ext = dma_mem_re ? src_mem[addr_ext] : 8'hzz;

  gb80_dma dut (
    .clock           (clock),
    .reset           (reset),
    .mem_we          (mem_we),
    .mem_re          (mem_re),
    .addr_ext        (addr_ext),
    .data_ext        (data_ext),
    .dma_mem_re      (dma_mem_re),
    .dma_mem_we      (dma_mem_we),
    .cpu_mem_disable (cpu_mem_disable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial stray_writes = 0;
  always @(posedge clock) begin
    if (dma_mem_we) begin
      if (addr_ext >= 16'hFE00 && addr_ext <= 16'hFE9F)
        oam[addr_ext - 16'hFE00] <= data_ext;
      else
        stray_writes <= stray_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic release_cpu();
    cpu_addr_oe = 1'b0;
    cpu_data_oe = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
  endtask

  task automatic check_released(input string tag);
    chk({tag, " re"},   {15'd0, dma_mem_re}, 16'd0);
    chk({tag, " we"},   {15'd0, dma_mem_we}, 16'd0);
    chk({tag, " dis"},  {15'd0, cpu_mem_disable}, 16'd0);
    chk({tag, " addr"}, addr_ext, 16'hFFFF);
    chk({tag, " data"}, {8'h00, data_ext}, 16'h00FF);
  endtask

  // One transfer from src; optional ignored-write pulse, START poke and mid-transfer reset.
  task automatic run_transfer(input logic [7:0] src, input int ign_cycle,
                              input bit poke_start, input int rst_cycle);
    int  nwritten;
    bit  aborted;
    for (int i = 0; i < 160; i++) begin
      exp_img[i] = src_mem[{src, 8'h00} + 16'(i)];
      old_img[i] = oam[i];
    end
    aborted  = 1'b0;
    nwritten = 160;
    cpu_addr = MMIO_DMA; cpu_data = src;
    cpu_addr_oe = 1'b1; cpu_data_oe = 1'b1; mem_we = 1'b1;
    @(posedge clock); #1;
    if (poke_start) cpu_data = 8'hC0;
    else release_cpu();
    #1;
    chk("c1 dis", {15'd0, cpu_mem_disable}, 16'd1);
    chk("c1 re",  {15'd0, dma_mem_re}, 16'd0);
    chk("c1 we",  {15'd0, dma_mem_we}, 16'd0);
    if (!poke_start) begin
      chk("c1 addr", addr_ext, 16'hFFFF);
      chk("c1 data", {8'h00, data_ext}, 16'h00FF);
    end
    for (int n = 2; n <= 322; n++) begin
      int          i;
      bit          rd;
      logic [15:0] ea;
      @(posedge clock); #1;
      release_cpu();
      if (n == ign_cycle) mem_we = 1'b1;
      #1;
      if (n == rst_cycle) begin
        reset = 1'b0;
        #1;
        check_released($sformatf("rst c%0d", n));
        nwritten = 0;
        for (int k = 0; k < 160; k++) if (2 * k + 3 < n) nwritten = k + 1;
        aborted = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        break;
      end
      if (n <= 321) begin
        i  = (n - 2) / 2;
        rd = ((n - 2) % 2) == 0;
        ea = rd ? ({src, 8'h00} + 16'(i)) : (16'hFE00 + 16'(i));
        chk($sformatf("c%0d addr", n), addr_ext, ea);
        chk($sformatf("c%0d re", n),  {15'd0, dma_mem_re}, {15'd0, rd});
        chk($sformatf("c%0d we", n),  {15'd0, dma_mem_we}, {15'd0, !rd});
        chk($sformatf("c%0d dis", n), {15'd0, cpu_mem_disable}, 16'd1);
        chk($sformatf("c%0d data", n), {8'h00, data_ext}, {8'h00, exp_img[i]});
      end else begin
        check_released("c322");
      end
    end
    release_cpu();
    #1;
    for (int i = 0; i < 160; i++)
      chk($sformatf("src %h oam %0d", src, i), {8'h00, oam[i]},
          {8'h00, (i < nwritten) ? exp_img[i] : old_img[i]});
    chk("stray writes", 16'(stray_writes), 16'd0);
    $display("transfer src=%h ign=%0d poke=%0d rst=%0d aborted=%0d bytes=%0d",
             src, ign_cycle, poke_start, rst_cycle, aborted, nwritten);
  endtask

  task automatic readback(input string tag, input logic [7:0] expv);
    cpu_addr = MMIO_DMA; cpu_addr_oe = 1'b1; mem_re = 1'b1;
    #2;
    chk(tag, {8'h00, data_ext}, {8'h00, expv});
    release_cpu();
    $display("readback %s data=%h", tag, data_ext);
  endtask

  initial begin
    logic [7:0] rb_exp;
    logic [7:0] srcs [0:3];
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    cpu_addr = 16'h0000; cpu_data = 8'h00;
    release_cpu();
    for (int a = 0; a < 65536; a++) src_mem[a] = 8'($urandom);
    for (int i = 0; i < 160; i++) src_mem[16'h8000 + 16'(i)] = 8'(i) ^ 8'h5A;
    #3;
    check_released("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_released("idle");

    run_transfer(8'h80, 0, 1'b0, 0);
`ifdef DMA_REG_READBACK_EN
    rb_exp = 8'h80;
`else
    rb_exp = 8'hFF;
`endif
    readback("rb after 80", rb_exp);

    for (int i = 0; i < 160; i++) src_mem[16'h8000 + 16'(i)] = 8'($urandom);
    run_transfer(8'h80, 50, 1'b1, 0);

    run_transfer(8'($urandom_range(1, 254)), 0, 1'b0, 100);
    run_transfer(8'h81, 0, 1'b0, 0);

    srcs[0] = 8'h00; srcs[1] = 8'hFF;
    srcs[2] = 8'($urandom); srcs[3] = 8'($urandom);
    for (int t = 0; t < 4; t++) begin
      @(posedge clock); #1;
      run_transfer(srcs[t], 0, 1'b0, 0);
    end

    @(posedge clock); #1;
    check_released("final idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
